// File: rtl/wb_host_bridge.sv
// wb_host_bridge: turns a byte-serial command stream into single 32-bit Wishbone cycles and streams back status/read data.
// Optional feature macro: WB_HOST_AUTOINC_EN enables opcode 'N' (read at last acknowledged address + 4).
module wb_host_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, GAP, RESP} state_t;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ST_K = 8'h4B;
    localparam logic [7:0] ST_T = 8'h54;
    localparam logic [7:0] ST_BAD = 8'h3F;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t state, state_nx;
    logic live, we_r;
    logic [1:0] byte_cnt;
    logic [15:0] tmo_cnt;
    logic [2:0] rsp_idx;
    logic [7:0] status;
    logic [31:0] rd_data, auto_adr;
    logic cmd_acc, rsp_acc, op_w, op_r, op_n, tmo, rsp_last;
    assign cmd_acc = cmd_valid && cmd_ready;
    assign rsp_acc = rsp_valid && rsp_ready;
    assign op_w = cmd_data == OP_W;
    assign op_r = cmd_data == OP_R;
    assign tmo = tmo_cnt == TMO_LAST;
    // a successful read returns status plus four data bytes, everything else only the status byte
    assign rsp_last = rsp_idx == ((status == ST_K && !we_r) ? 3'd4 : 3'd0);
    assign wbm_sel_o = 4'hF;
`ifdef WB_HOST_AUTOINC_EN
    logic [31:0] last_adr;
    assign op_n = cmd_data == 8'h4E;
    assign auto_adr = last_adr + 32'd4;
    // remember the address of the last acknowledged cycle for auto-increment reads
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) last_adr <= '0;
        else if (state == BUS && wbm_ack_i) last_adr <= wbm_adr_o;
`else
    assign op_n = 1'b0;
    assign auto_adr = wbm_adr_o;
`endif
    // state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) state <= IDLE;
        else state <= state_nx;
    // next-state logic; ack has priority over a timeout expiring in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_acc) state_nx = (op_w || op_r) ? ADDR : op_n ? BUS : RESP;
            ADDR: if (cmd_acc && byte_cnt == 2'd3) state_nx = we_r ? DATA : BUS;
            DATA: if (cmd_acc && byte_cnt == 2'd3) state_nx = BUS;
            BUS:  if (wbm_ack_i || tmo) state_nx = GAP;
            GAP:  if (!wbm_ack_i) state_nx = RESP;
            RESP: if (rsp_acc && rsp_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // outputs decoded from state; cmd_ready stays low until the first edge after reset
    always_comb begin
        cmd_ready = live && (state == IDLE || state == ADDR || state == DATA);
        wbm_cyc_o = state == BUS;
        wbm_stb_o = state == BUS;
        wbm_we_o = state == BUS && we_r;
        rsp_valid = state == RESP;
        rsp_data = rsp_idx == 3'd0 ? status : rsp_idx == 3'd1 ? rd_data[31:24] :
                   rsp_idx == 3'd2 ? rd_data[23:16] : rsp_idx == 3'd3 ? rd_data[15:8] : rd_data[7:0];
    end
    // command field shifting, bus result capture and response sequencing
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            live <= 1'b0;
            we_r <= 1'b0;
            byte_cnt <= '0;
            tmo_cnt <= '0;
            rsp_idx <= '0;
            status <= '0;
            rd_data <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            live <= 1'b1;
            tmo_cnt <= state == BUS ? tmo_cnt + 16'd1 : '0;
            rsp_idx <= state != RESP ? '0 : rsp_idx + 3'(rsp_acc);
            if (cmd_acc) byte_cnt <= state == IDLE ? 2'd0 : byte_cnt + 2'd1;
            if (cmd_acc && state == IDLE) begin
                we_r <= op_w;
                if (!(op_w || op_r || op_n)) status <= ST_BAD;
                if (op_n) wbm_adr_o <= auto_adr;
            end
            if (cmd_acc && state == ADDR) wbm_adr_o <= {wbm_adr_o[23:0], cmd_data};
            if (cmd_acc && state == DATA) wbm_dat_o <= {wbm_dat_o[23:0], cmd_data};
            if (state == BUS && (wbm_ack_i || tmo)) status <= wbm_ack_i ? ST_K : ST_T;
            if (state == BUS && wbm_ack_i && !we_r) rd_data <= wbm_dat_i;
        end
endmodule

// File: tb/tb_wb_host_bridge.sv
// tb_wb_host_bridge: directed and randomized transactions against a transaction-level model of wb_host_bridge.
module tb_wb_host_bridge;
    localparam int TMO = 8;
`ifdef WB_HOST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    logic wb_clk_i = 1'b0, wb_rst_ni = 1'b0;
    logic [7:0] cmd_data = '0, rsp_data;
    logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
    logic [3:0] wbm_sel_o;
    int checks = 0, errors = 0;
    // slave model configuration and observations
    int s_delay = 1, s_linger = 0;
    bit s_no_ack = 1'b0;
    logic [31:0] s_word = '0;
    int ack_left = 0, stb_n = 0, stb_len = 0, n_cycles = 0, we_bad = 0, rsp_early = 0, overlap = 0;
    logic [31:0] cap_adr = '0, cap_dat = '0;
    logic cap_we = 1'b0;
    // reference model state
    logic [31:0] m_last = '0;
    logic [7:0] exp_q[$];

    wb_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: acks after s_delay strobe cycles, holds ack s_linger extra cycles
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
        forever begin
            @(negedge wb_clk_i);
            if (!wbm_cyc_o && wbm_we_o) we_bad++;
            if (rsp_valid && wbm_ack_i) rsp_early++;
            if (ack_left > 0) begin
                if (wbm_cyc_o) overlap++;
                ack_left--;
                if (ack_left == 0) begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = $urandom;
                end
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (stb_n == 0) n_cycles++;
                stb_n++;
                stb_len = stb_n;
                cap_adr = wbm_adr_o;
                cap_dat = wbm_dat_o;
                cap_we = wbm_we_o;
                if (!s_no_ack && stb_n == s_delay) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = s_word;
                    ack_left = 1 + s_linger;
                end
            end else stb_n = 0;
        end
    end

    // called at a negedge; returns at the negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("cmd_ready", cmd_ready, 1);
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
        @(negedge wb_clk_i);
    endtask

    // drains exp_q.size() response bytes, stalling before byte stall_idx for stall_len cycles
    task automatic get_rsp(input int stall_idx, input int stall_len);
        int n, st;
        logic [7:0] held;
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge wb_clk_i);
                n++;
            end
            check("rsp_valid", rsp_valid, 1);
            if (!rsp_valid) return;
            held = rsp_data;
            st = (i == stall_idx) ? stall_len : $urandom_range(0, 1);
            for (int k = 0; k < st; k++) begin
                @(negedge wb_clk_i);
                check("rsp_stable", {rsp_valid, rsp_data}, {1'b1, held});
            end
            check("rsp_byte", rsp_data, exp_q[i]);
            rsp_ready = 1'b1;
            @(posedge wb_clk_i);
            #1 rsp_ready = 1'b0;
            @(negedge wb_clk_i);
        end
    endtask

    task automatic do_txn(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [31:0] word, input int delay, input int linger, input bit no_ack,
                          input int stall_idx, input int stall_len);
        bit is_bus, acked, is_w;
        logic [31:0] exp_adr;
        int start_n;
        is_w = op == 8'h57;
        is_bus = is_w || op == 8'h52 || (AUTOINC && op == 8'h4E);
        acked = is_bus && !no_ack && delay <= TMO;
        exp_adr = op == 8'h4E ? m_last + 32'd4 : adr;
        exp_q.delete();
        if (!is_bus) exp_q.push_back(8'h3F);
        else if (!acked) exp_q.push_back(8'h54);
        else begin
            exp_q.push_back(8'h4B);
            if (!is_w) for (int i = 3; i >= 0; i--) exp_q.push_back(word[8*i +: 8]);
        end
        if (acked) m_last = exp_adr;
        s_delay = delay;
        s_linger = linger;
        s_no_ack = no_ack;
        s_word = word;
        start_n = n_cycles;
        send_byte(op);
        if (is_w || op == 8'h52) for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
        if (is_w) for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
        if (is_bus) check("stb_latency", wbm_stb_o, 1);
        get_rsp(stall_idx, stall_len);
        check("cycle_count", n_cycles - start_n, is_bus ? 1 : 0);
        if (is_bus) begin
            check("bus_adr", cap_adr, exp_adr);
            check("bus_we", cap_we, is_w);
            if (is_w) check("bus_dat", cap_dat, dat);
            check("stb_len", stb_len, acked ? delay : TMO);
        end
        check("back_idle", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk_i);
        check("rst_ctrl", {cmd_ready, rsp_valid, rsp_data, wbm_we_o, wbm_cyc_o, wbm_stb_o}, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_sel", wbm_sel_o, 4'hF);
        wb_rst_ni = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        // plan: write, read with mid-stream stall, auto-increment, timeout, ack at timeout boundary
        do_txn(8'h57, 32'h0008_0000, 32'h0000_0029, 32'h0, 3, 0, 1'b0, -1, 0);
        do_txn(8'h52, 32'h0008_0000, 32'h0, 32'h0000_009D, 2, 0, 1'b0, 2, 5);
        do_txn(8'h4E, 32'h0, 32'h0, 32'hCAFE_0123, 4, 0, 1'b0, -1, 0);
        do_txn(8'h52, 32'h0, 32'h0, 32'h1234_5678, 1, 0, 1'b1, -1, 0);
        do_txn(8'h52, 32'h0000_0010, 32'h0, 32'h0000_55AA, TMO, 0, 1'b0, -1, 0);
        // lingering ack followed by a back-to-back read
        do_txn(8'h52, 32'h0000_0100, 32'h0, 32'h1122_3344, 1, 2, 1'b0, -1, 0);
        do_txn(8'h52, 32'h0000_0104, 32'h0, 32'h5566_7788, 1, 2, 1'b0, -1, 0);
        // bad opcode, then auto-increment address wrap
        do_txn(8'h41, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0, -1, 0);
        do_txn(8'h52, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_F00D, 2, 0, 1'b0, -1, 0);
        do_txn(8'h4E, 32'h0, 32'h0, 32'h7777_0000, 2, 1, 1'b0, -1, 0);
        // reset while the bus cycle is outstanding
        s_no_ack = 1'b1;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h40);
        check("pre_rst_cyc", wbm_cyc_o, 1);
        #1 wb_rst_ni = 1'b0;
        #1 check("rst_drop", {wbm_cyc_o, wbm_stb_o, wbm_we_o, cmd_ready, rsp_valid}, 0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        m_last = '0;
        repeat (2) @(negedge wb_clk_i);
        check("rst_idle", {cmd_ready, rsp_valid, wbm_adr_o}, {1'b1, 1'b0, 32'h0});
        // partial frame discarded by reset: the next byte must be decoded as an opcode
        send_byte(8'h57);
        send_byte(8'h12);
        #1 wb_rst_ni = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        do_txn(8'h41, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0, -1, 0);
        do_txn(8'h4E, 32'h0, 32'h0, 32'h0000_4444, 3, 0, 1'b0, -1, 0);
        // randomized traffic
        repeat (25) begin
            logic [7:0] op;
            int pick;
            pick = $urandom_range(0, 3);
            op = pick == 0 ? 8'h57 : pick == 1 ? 8'h52 : pick == 2 ? 8'h4E : 8'($urandom_range(0, 255));
            if (pick == 3 && (op == 8'h57 || op == 8'h52 || op == 8'h4E)) op = 8'h00;
            do_txn(op, $urandom, $urandom, $urandom, $urandom_range(1, TMO), $urandom_range(0, 2),
                   $urandom_range(0, 9) == 0, -1, 0);
        end
        check("we_outside_cyc", we_bad, 0);
        check("rsp_during_ack", rsp_early, 0);
        check("cyc_during_linger", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
